rgb_pwm_fader: RTL and testbench



---
 rtl/rgb_pwm_fader_if.sv | 21 ++
 rtl/rgb_pwm_fader.sv | 129 ++++++++++++
 tb/tb_rgb_pwm_fader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_fader_if.sv
// Pin bundle between the colour FSM, the RGB PWM fader and the LED pins.
// The fader is the slave. The colour FSM or the bench is the master.
interface rgb_pwm_fader_if;
    logic red_in;
    logic green_in;
    logic blue_in;
    logic red_pwm;
    logic green_pwm;
    logic blue_pwm;
    logic settled;

    modport master (
        output red_in, green_in, blue_in,
        input  red_pwm, green_pwm, blue_pwm, settled
    );

    modport slave (
        input  red_in, green_in, blue_in,
        output red_pwm, green_pwm, blue_pwm, settled
    );
endinterface

// File: rtl/rgb_pwm_fader.sv
// RGB LED driver. Each channel fades linearly toward its 0/255 target and drives 8-bit PWM.
// Optional macro GAMMA_EN applies a squared perceptual curve, with one extra pipeline stage.
module rgb_pwm_fader #(
    parameter int unsigned STEP_CYCLES = 23_529,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    rgb_pwm_fader_if.slave io
);

    localparam int unsigned NCH = 3;
    localparam int unsigned SW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {HOLD, RAMP_UP, RAMP_DOWN} ch_state_t;

    logic [NCH-1:0] din;
    logic [NCH-1:0] target;
    logic [7:0]     duty      [NCH];
    logic [7:0]     duty_nxt  [NCH];
    logic [7:0]     level     [NCH];
    logic [7:0]     eff       [NCH];
    ch_state_t      state     [NCH];
    ch_state_t      state_nxt [NCH];
    logic [SW-1:0]  step_cnt;
    logic           tick;
    logic [7:0]     pwm_cnt;
    logic [NCH-1:0] on;
    logic [NCH-1:0] pwm_q;
    logic           settled_q;
    logic           settled_nxt;

    // Channel index 0 is red, 1 is green and 2 is blue.
    assign din  = {io.blue_in, io.green_in, io.red_in};
    assign tick = (step_cnt == STEP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target    <= '0;
            step_cnt  <= '0;
            pwm_cnt   <= '0;
            pwm_q     <= {NCH{ACTIVE_LOW}};
            settled_q <= 1'b1;
        end else begin
            target    <= din;
            step_cnt  <= tick ? '0 : step_cnt + 1'b1;
            pwm_cnt   <= pwm_cnt + 8'd1;
            pwm_q     <= on ^ {NCH{ACTIVE_LOW}};
            settled_q <= settled_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                state[c] <= HOLD;
                duty[c]  <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                state[c] <= state_nxt[c];
                duty[c]  <= duty_nxt[c];
            end
        end
    end

    // The step direction comes from the current state. The next state is chosen
    // from the already-stepped duty. A target flip therefore takes effect one
    // cycle later, and reaching the level lands in HOLD on the same edge.
    always_comb begin
        settled_nxt = 1'b1;
        for (int unsigned c = 0; c < NCH; c++) begin
            level[c]    = target[c] ? '1 : '0;
            duty_nxt[c] = duty[c];
            unique case (state[c])
                RAMP_UP:   if (tick && duty[c] != '1) duty_nxt[c] = duty[c] + 8'd1;
                RAMP_DOWN: if (tick && duty[c] != '0) duty_nxt[c] = duty[c] - 8'd1;
                default:   ;
            endcase
            if (duty_nxt[c] == level[c])
                state_nxt[c] = HOLD;
            else if (level[c] > duty_nxt[c])
                state_nxt[c] = RAMP_UP;
            else
                state_nxt[c] = RAMP_DOWN;
            if (state[c] != HOLD || duty[c] != level[c])
                settled_nxt = 1'b0;
        end
    end

`ifdef GAMMA_EN
    logic [15:0] sq    [NCH];
    logic [7:0]  eff_q [NCH];

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++)
            sq[c] = {8'd0, duty[c]} * {8'd0, duty[c]} + 16'd255;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NCH; c++) eff_q[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) eff_q[c] <= 8'(sq[c] >> 8);
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) eff[c] = eff_q[c];
    end
`else
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) eff[c] = duty[c];
    end
`endif

    always_comb begin
        on = '0;
        for (int unsigned c = 0; c < NCH; c++)
            on[c] = (eff[c] == '1) || (pwm_cnt < eff[c]);
    end

    assign io.red_pwm   = pwm_q[0];
    assign io.green_pwm = pwm_q[1];
    assign io.blue_pwm  = pwm_q[2];
    assign io.settled   = settled_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Self-checking bench for rgb_pwm_fader: a table of steady states, a per-cycle reference scoreboard,
// and hand-written fade/reset sequences. A second, slower instance measures PWM low-time at a held duty.
module tb_rgb_pwm_fader;
    localparam int STEP = 4;
    localparam int SLOW = 300;
    localparam bit AL   = 1'b1;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rst_n_s = 1'b0;

    rgb_pwm_fader_if if_f();
    rgb_pwm_fader_if if_s();

    rgb_pwm_fader #(.STEP_CYCLES(STEP), .ACTIVE_LOW(AL)) u_dut (
        .clk(clk), .rst_n(rst_n), .io(if_f)
    );
    rgb_pwm_fader #(.STEP_CYCLES(SLOW), .ACTIVE_LOW(AL)) u_slow (
        .clk(clk), .rst_n(rst_n_s), .io(if_s)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [3:0] sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: actual %0d, expected %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
        end
    endtask

    function automatic int eff_of(input int d);
`ifdef GAMMA_EN
        return (d * d + 255) / 256;
`else
        return d;
`endif
    endfunction

    task automatic drive_f(input logic [2:0] rgb);
        if_f.red_in   = rgb[2];
        if_f.green_in = rgb[1];
        if_f.blue_in  = rgb[0];
    endtask

    // Reference model. Channel 0 is red, 1 is green and 2 is blue. dir is +1 (up), -1 (down) or 0 (hold).
    int m_t[3], m_dir[3], m_duty[3], m_g[3];
    int m_step = 0;
    int m_cnt  = 0;

    initial begin
        for (int c = 0; c < 3; c++) begin
            m_t[c] = 0; m_dir[c] = 0; m_duty[c] = 0; m_g[c] = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin : model
        logic [2:0] pw;
        logic [2:0] in_v;
        logic       ok;
        bit         tick;
        int         lvl, cmp, nd;
        if (!rst_n) begin
            sb.delete();
            m_step = 0;
            m_cnt  = 0;
            for (int c = 0; c < 3; c++) begin
                m_t[c] = 0; m_dir[c] = 0; m_duty[c] = 0; m_g[c] = 0;
            end
        end else begin
            in_v = {if_f.red_in, if_f.green_in, if_f.blue_in};
            tick = (m_step == STEP - 1);
            ok   = 1'b1;
            for (int c = 0; c < 3; c++) begin
                lvl = (m_t[c] != 0) ? 255 : 0;
`ifdef GAMMA_EN
                cmp = m_g[c];
`else
                cmp = m_duty[c];
`endif
                pw[2-c] = logic'((cmp == 255) || (m_cnt < cmp)) ^ AL;
                if (m_duty[c] != lvl) ok = 1'b0;
                nd = m_duty[c] + (tick ? m_dir[c] : 0);
                if (nd > 255) nd = 255;
                if (nd < 0)   nd = 0;
                m_g[c]    = (m_duty[c] * m_duty[c] + 255) / 256;
                m_duty[c] = nd;
                m_dir[c]  = (nd < lvl) ? 1 : (nd > lvl) ? -1 : 0;
                m_t[c]    = int'(in_v[2-c]);
            end
            sb.push_back({pw, ok});
            m_step = tick ? 0 : m_step + 1;
            m_cnt  = (m_cnt + 1) % 256;
        end
    end

    always @(posedge clk) begin
        logic [3:0] e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("stream_pwm", {if_f.red_pwm, if_f.green_pwm, if_f.blue_pwm}, e[3:1]);
            check("stream_settled", if_f.settled, e[0]);
        end
    end

    typedef struct {
        logic [2:0] rgb;
        int         cycles;
        logic [2:0] exp_pwm;
        logic       exp_set;
    } vec_t;

    task automatic fast_seq();
        vec_t tbl[5];
        int   e, cnt, pk;
        tbl[0] = '{3'b000,  300, 3'b111, 1'b1};
        tbl[1] = '{3'b100, 1100, 3'b011, 1'b1};
        tbl[2] = '{3'b111, 1100, 3'b000, 1'b1};
        tbl[3] = '{3'b010, 1100, 3'b101, 1'b1};
        tbl[4] = '{3'b000, 1100, 3'b111, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) drive_f(tbl[i].rgb);
            repeat (tbl[i].cycles) @(posedge clk);
            #1;
            check($sformatf("tbl%0d_pwm", i), {if_f.red_pwm, if_f.green_pwm, if_f.blue_pwm}, tbl[i].exp_pwm);
            check($sformatf("tbl%0d_settled", i), if_f.settled, tbl[i].exp_set);
        end

        // Full red fade from 0: settled drops two edges after the input change and returns after 255 ticks.
        @(negedge clk) drive_f(3'b100);
        @(posedge clk); #1 check("t2_settled_e1", if_f.settled, 1'b1);
        @(posedge clk); #1 check("t2_settled_e2", if_f.settled, 1'b0);
        e = 2;
        while (if_f.settled !== 1'b1 && e < 1200) begin
            @(posedge clk); #1; e++;
        end
        check_range("t2_fade_edges", e, 1016, 1028);
        cnt = 0;
        repeat (256) begin @(posedge clk); #1; if (if_f.red_pwm !== 1'b0) cnt++; end
        check("t2_red_full_on_high_cycles", cnt, 0);

        // Blue ramps up to 100, then the target is dropped. The fade reverses with no overshoot.
        @(negedge clk) drive_f(3'b101);
        e = 0;
        while (m_duty[2] != 100 && e < 600) begin @(posedge clk); #1; e++; end
        check("t4_reach100_in_budget", e < 600, 1'b1);
        @(negedge clk) drive_f(3'b100);
        e = 0; pk = 0;
        while (if_f.settled !== 1'b1 && e < 600) begin
            @(posedge clk); #1; e++;
            if (int'(u_dut.duty[2]) > pk) pk = int'(u_dut.duty[2]);
        end
        check("t4_peak_duty", pk, 100);
        check_range("t4_fall_edges", e, 396, 406);
        cnt = 0;
        repeat (256) begin @(posedge clk); #1; if (if_f.blue_pwm === 1'b1) cnt++; end
        check("t4_blue_off_high_cycles", cnt, 256);

        // Asynchronous reset mid-ramp, asserted and released away from the clock edge.
        @(negedge clk) drive_f(3'b110);
        repeat (50) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_pwm_in_reset", {if_f.red_pwm, if_f.green_pwm, if_f.blue_pwm}, 3'b111);
        check("t5_settled_in_reset", if_f.settled, 1'b1);
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        check("t5_settled_after", if_f.settled, 1'b1);
        check("t5_pwm_after", {if_f.red_pwm, if_f.green_pwm, if_f.blue_pwm}, 3'b111);
        check("t5_green_duty_after", u_dut.duty[1], 0);
        repeat (300) @(posedge clk);
        #1 check("t5_fading_again", if_f.settled, 1'b0);
    endtask

    // Slow instance: the duty changes only every 300 edges, so a full PWM period can be measured at a fixed duty.
    task automatic slow_seq();
        int e, cnt;
        @(negedge clk) rst_n_s = 1'b1;
        e = 0;
        for (int d = 64; d < 68; d++) begin
            while (e < SLOW * d + 2) begin @(posedge clk); e++; end
            cnt = 0;
            repeat (256) begin @(posedge clk); #1; e++; if (if_s.red_pwm === 1'b0) cnt++; end
            check($sformatf("t3_lowtime_duty%0d", d), cnt, eff_of(d));
        end
    endtask

    initial begin
        drive_f(3'b000);
        if_s.red_in   = 1'b1;
        if_s.green_in = 1'b0;
        if_s.blue_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pwm", {if_f.red_pwm, if_f.green_pwm, if_f.blue_pwm}, 3'b111);
        check("rst_settled", if_f.settled, 1'b1);
        check("rst_slow_pwm", {if_s.red_pwm, if_s.green_pwm, if_s.blue_pwm}, 3'b111);
        @(negedge clk) rst_n = 1'b1;
        fork
            fast_seq();
            slow_seq();
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached, actual timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end
endmodule
